// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: states, command/response bytes and peripheral map of the UART bus master
package uart_bus_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, ACCESS, SEND, WAITTX} state_t;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
    localparam logic [31:0] PERIPH_END = 32'h4000_0020;
endpackage

// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: UART byte stream and simple bus strobes of the UART bus master
interface uart_bus_master_if;
    logic rx_valid;
    logic [7:0] rx_data;
    logic tx_ready;
    logic tx_en;
    logic [7:0] tx_data;
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic busy;
    modport master(
        input rx_valid, rx_data, tx_ready, rdata,
        output tx_en, tx_data, rd, wr, addr, wdata, busy
    );
    modport slave(
        output rx_valid, rx_data, tx_ready, rdata,
        input tx_en, tx_data, rd, wr, addr, wdata, busy
    );
endinterface

// File: rtl/uart_timeout_counter.sv
// uart_timeout_counter: saturating 32-bit idle counter with clear and expiry flag
module uart_timeout_counter #(
    parameter int unsigned LIMIT = 1000000
) (
    input logic sysclk,
    input logic reset,
    input logic clear,
    output logic expired
);
    logic [31:0] cnt;
    always_ff @(posedge sysclk) begin
        if (reset || clear) cnt <= '0;
        else if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
    assign expired = cnt >= LIMIT;
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes W/R command frames from a UART byte stream into bus accesses
// and streams the response bytes back, MSB first.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic sysclk,
    input logic reset,
    uart_bus_master_if.master bus
);
    state_t state, state_n;
    logic is_write;
    logic [1:0] idx;
    logic [1:0] rem;
    logic seen_low;
    logic [31:0] resp;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic rx_ok;
    logic expired;
    uart_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .sysclk(sysclk),
        .reset(reset),
        .clear(rx_ok || !(state == ADDR || state == WDATA)),
        .expired(expired)
    );
    always_comb begin
        state_n = state;
        rx_ok = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.tx_en = 1'b0;
        case (state)
            IDLE: if (bus.rx_valid) begin
                rx_ok = 1'b1;
                state_n = (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) ? ADDR : SEND;
            end
            ADDR: if (bus.rx_valid) begin
                rx_ok = 1'b1;
                if (idx == 2'd3) state_n = is_write ? WDATA : ACCESS;
            end else if (expired) state_n = IDLE;
            WDATA: if (bus.rx_valid) begin
                rx_ok = 1'b1;
                if (idx == 2'd3) state_n = ACCESS;
            end else if (expired) state_n = IDLE;
            ACCESS: begin
                bus.wr = is_write;
                bus.rd = !is_write;
                state_n = SEND;
            end
            SEND: if (bus.tx_ready) begin
                bus.tx_en = 1'b1;
                state_n = WAITTX;
            end
            WAITTX: if (seen_low && bus.tx_ready) state_n = (rem != 2'd0) ? SEND : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // resp holds the outgoing byte in its top lane; it only shifts when WAITTX hands over
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
            is_write <= 1'b0;
            idx <= '0;
            rem <= '0;
            seen_low <= 1'b0;
            resp <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            idx <= (state_n != state) ? 2'd0 : idx + {1'b0, rx_ok};
            seen_low <= (state_n != state) ? 1'b0 : seen_low | ~bus.tx_ready;
            if (state == IDLE && rx_ok) begin
                is_write <= bus.rx_data == CMD_WRITE;
                resp <= {RSP_ERR, 24'h0};
                rem <= 2'd0;
            end
            if (state == ADDR && rx_ok) addr_q <= {addr_q[23:0], bus.rx_data};
            if (state == WDATA && rx_ok) wdata_q <= {wdata_q[23:0], bus.rx_data};
            if (state == ACCESS) begin
                resp <= is_write ? {RSP_OK, 24'h0} : bus.rdata;
                rem <= is_write ? 2'd0 : 2'd3;
            end
            if (state == WAITTX && state_n == SEND) begin
                resp <= {resp[23:0], 8'h0};
                rem <= rem - 2'd1;
            end
        end
    end
    assign bus.addr = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.tx_data = resp[31:24];
    assign bus.busy = state != IDLE;
endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed between received bytes of one frame.
REQ-002 SHALL have one clock and synchronous active-high reset, with ports:
  sysclk  in  1  clock; all state updates on its rising edge.
  reset   in  1  synchronous, active-high reset.
REQ-003 SHALL have these UART-side ports:
  rx_valid  in   1   one-cycle pulse; rx_data holds a new byte.
  rx_data   in   8   received byte.
  tx_ready  in   1   sender idle; may accept a byte.
  tx_en     out  1   one-cycle pulse: send tx_data.
  tx_data   out  8   byte to send.
REQ-004 SHALL have these bus-side ports:
  rd     out  1   one-cycle read strobe.
  wr     out  1   one-cycle write strobe.
  addr   out  32  bus address.
  wdata  out  32  bus write data.
  rdata  in   32  read data, combinationally valid in the cycle rd=1.
  busy   out  1   high in any state except IDLE.

Function
REQ-005 SHALL implement states IDLE, ADDR, WDATA, ACCESS, SEND and WAITTX.
REQ-006 SHALL, in IDLE, treat a received byte as a command: 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); any other byte -> queue response 0x3F '?' and enter SEND.
REQ-007 SHALL, in ADDR, shift in 4 bytes MSB first into addr, then go to WDATA if writing or ACCESS if reading.
REQ-008 SHALL, in WDATA, shift in 4 bytes MSB first into wdata, then go to ACCESS.
REQ-009 SHALL, in ACCESS, assert exactly one of wr/rd for exactly one cycle, then go to SEND.
REQ-010 SHALL, on a write access, queue a 1-byte response 0x4B 'K'.
REQ-011 SHALL, on a read access, capture rdata in that same cycle and queue a 4-byte response, MSB first.
REQ-012 SHALL, in SEND, pulse tx_en for one cycle with tx_data valid whenever tx_ready=1, then go to WAITTX.
REQ-013 SHALL, in WAITTX, wait for tx_ready to fall and then rise again; it then returns to SEND if bytes remain, else to IDLE.
REQ-014 SHALL keep tx_data stable from the tx_en pulse until leaving WAITTX.
REQ-015 SHALL ignore rx_valid in ACCESS, SEND and WAITTX; bytes arriving then are dropped.
REQ-016 SHALL, in ADDR or WDATA, count cycles since the last received byte (32-bit, saturating). When the count reaches TIMEOUT_CYCLES it SHALL return to IDLE, with no bus access and no response.
REQ-017 SHALL reset the timeout counter on every accepted rx_valid, and hold it at 0 in IDLE.
REQ-018 SHALL never assert rd and wr together, and never assert tx_en outside SEND.
REQ-019 SHALL, when a timeout and rx_valid coincide, accept the byte and not time out.
REQ-020 SHALL count bytes with a 2-bit index that resets to 0 on every state entry.

Reset
REQ-021 SHALL, with reset=1 at a clock edge, enter IDLE and clear: rd, wr, tx_en, busy to 0; addr, wdata, tx_data to 0; byte index, timeout counter and response buffer to 0.
REQ-022 SHALL, on reset mid-frame or mid-response, abandon the frame and emit no further tx_en or bus strobe.

Structure
REQ-023 SHALL take its state encoding and command/response constants (0x57, 0x52, 0x4B, 0x3F) from a shared package, uart_bus_pkg, together with the peripheral address map (0x40000000-0x40000020).
REQ-024 SHALL contain one sub-module, uart_timeout_counter: saturating counter with clear and expiry flag.
REQ-025 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-026 Bench SHALL cover a write: bytes 57 40 00 00 0C 00 00 00 A5 -> one wr pulse with addr=0x4000000C, wdata=0x000000A5; then tx byte 4B.
REQ-027 Bench SHALL cover a read: bytes 52 40 00 00 10 with rdata=0x0000003C -> one rd pulse with addr=0x40000010; then tx bytes 00 00 00 3C in order.
REQ-028 Bench SHALL cover a bad command: byte 41 -> tx byte 3F, no rd/wr, busy returns to 0.
REQ-029 Bench SHALL cover a timeout, with TIMEOUT_CYCLES=100: bytes 57 40 then silence for 100 cycles -> IDLE, no wr, no tx_en; a subsequent full write frame completes normally.
REQ-030 Bench SHALL cover tx backpressure: tx_ready held low for 50 cycles during a read response -> no tx_en while low, 4 bytes still sent in order, and bytes sent meanwhile on rx are dropped.
REQ-031 Bench SHALL cover reset mid-frame: reset after 52 40 00 -> all outputs 0, and a following 52 frame is decoded from its first byte.
